// File: rtl/tetris_nios_debug_mem_bridge.sv
// Bridges Nios II OCI memory debug commands onto a single-word Avalon-MM master.
// One transaction at a time, auto-incrementing word address, timeout abort with sticky error.
module tetris_nios_debug_mem_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TIMEOUT  = 1023,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              cmd_overrun,
    output logic [ADDR_W+1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic [31:0]       m_readdata,
    input  logic              m_waitrequest,
    input  logic              m_readdatavalid
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        mon_q, mon_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;

    logic is_idle, drop, rd_done, wr_done, timeout_hit, timeout_set;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mon_d       = mon_q;
        wdata_d     = wdata_q;
        timer_d     = timer_q;
        ready_d     = ready_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        timeout_set = 1'b0;

        is_idle     = (state_q == IDLE);
        // a+b together in IDLE runs a and drops b; any strobe while busy is dropped
        drop        = (take_action_ocimem_a || take_action_ocimem_b) &&
                      (!is_idle || (take_action_ocimem_a && take_action_ocimem_b));
        // zero-latency slaves may return data on the same edge the read is accepted
        rd_done     = (((state_q == RD_REQ) && !m_waitrequest) || (state_q == RD_WAIT)) &&
                      m_readdatavalid;
        wr_done     = (state_q == WR_REQ) && !m_waitrequest;
        timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));

        case (state_q)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[ADDR_W+1:2];
                    if (jdo[35]) begin
                        state_d = RD_REQ;
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                        timer_d = '0;
                    end
                end else if (take_action_ocimem_b) begin
                    ready_d = 1'b0;
                    timer_d = '0;
                    if (jdo[35]) begin
                        state_d = WR_REQ;
                        wr_d    = 1'b1;
                        wdata_d = jdo[34:3];
                    end else begin
                        state_d = RD_REQ;
                        rd_d    = 1'b1;
                    end
                end
            end
            default: begin
                timer_d = timer_q + TMR_W'(1);
                // completion takes priority so a response in the last allowed cycle succeeds
                if (rd_done) begin
                    mon_d   = m_readdata;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    ready_d = 1'b1;
                end else if (wr_done) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    ready_d = 1'b1;
                end else if (timeout_hit) begin
                    mon_d       = ERR_DATA;
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    ready_d     = 1'b1;
                end else if ((state_q == RD_REQ) && !m_waitrequest) begin
                    state_d = RD_WAIT;
                    rd_d    = 1'b0;
                end
            end
        endcase

        // a new set event wins over a coincident clear
        if (timeout_set)                  err_d = 1'b1;
        else if (take_no_action_ocimem_a) err_d = 1'b0;
        else                              err_d = err_q;

        if (drop)                         ovr_d = 1'b1;
        else if (take_no_action_ocimem_a) ovr_d = 1'b0;
        else                              ovr_d = ovr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            timer_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
    assign cmd_overrun   = ovr_q;
    assign m_address     = {addr_q, 2'b00};
    assign m_read        = rd_q;
    assign m_write       = wr_q;
    assign m_writedata   = wdata_q;
    assign m_byteenable  = 4'hF;

endmodule
